dram_bridge: RTL

- Responder for the single-word DRAM request port that the memory decoder drives for addresses at or above $10000 (RAM2).
- Converts each 32-bit read or write into a 128-bit command/write-data/read-data transaction on a native DRAM-controller application interface.
- Holds `dram_wait` high until the transaction completes.
- Keeps a one-line (16-byte) read buffer, so that sequential instruction and data reads within a line complete with zero wait states.

---
 rtl/dram_bridge_pkg.sv | 28 ++
 rtl/dram_bridge_line_buffer.sv | 67 ++++++
 rtl/dram_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dram_bridge_pkg.sv
// dram_bridge_pkg
//   Shared definitions for the RAM2 DRAM bridge: FSM state encoding, the
//   native application-interface command codes, and line geometry
//   (four 32-bit words per 128-bit line).
package dram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_XFER = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] APP_CMD_READ  = 3'b001;
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;

  localparam int LINE_WORDS = 4;
  // Tag is the full word address above the line offset: dram_addr[31:4].
  localparam int TAG_W      = 28;

  // Byte mask for a single-word write: 1 = keep, 0 = write. Only the four
  // byte enables of the selected lane are cleared.
  function automatic logic [15:0] lane_mask(input logic [1:0] w);
    return ~(16'h000F << {w, 2'b00});
  endfunction

endpackage

// File: rtl/dram_bridge_line_buffer.sv
// line_buffer
//   One-line read buffer: 128-bit data, tag and valid bit.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset (clears tag/valid)
//     invalidate      synchronous drop of the valid bit
//     fill_en         load a whole line plus its tag and mark it valid
//     fill_data/tag   line and tag to load
//     word_we         overwrite one 32-bit lane (write-through path)
//     word_sel/data   lane index and word for word_we
//     line_data, tag, valid   current contents
module line_buffer
  import dram_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             invalidate,
  input  logic             fill_en,
  input  logic [127:0]     fill_data,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             word_we,
  input  logic [1:0]       word_sel,
  input  logic [31:0]      word_data,
  output logic [127:0]     line_data,
  output logic [TAG_W-1:0] tag,
  output logic             valid
);

  logic [127:0]     data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill_en) begin
      data_d  = fill_data;
      tag_d   = fill_tag;
      valid_d = 1'b1;
    end else if (word_we) begin
      data_d[{word_sel, 5'b00000} +: 32] = word_data;
    end
    if (invalidate) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  // Line contents are meaningless while valid is low, so they carry no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign line_data = data_q;
  assign tag       = tag_q;
  assign valid     = valid_q;

endmodule

// File: rtl/dram_bridge.sv
// dram_bridge
//   Responder for the single-word RAM2 request port. Each 32-bit read or
//   write becomes one 128-bit transaction on a native DRAM-controller
//   application interface; dram_wait stalls the initiator until done.
//   A one-line read buffer lets reads within the last fetched line finish
//   with zero wait states; writes that hit it are written through.
//   Ports:
//     clk, rst                         clock, asynchronous active-high reset
//     dram_addr/_write_data            request address and write word
//     dram_read_enable/_write_enable   request strobes, held while waiting
//     dram_read_data                   registered read word
//     dram_wait                        combinational stall
//     app_addr/_cmd/_en/_rdy           backend command channel
//     app_wdf_data/_mask/_wren/_end/_rdy   backend write-data channel
//     app_rd_data/_valid               backend read-data channel
//     init_calib_complete              backend ready for traffic
module dram_bridge
  import dram_bridge_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int LINE_WIDTH     = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dram_addr,
  output logic [31:0]               dram_read_data,
  input  logic [31:0]               dram_write_data,
  input  logic                      dram_read_enable,
  input  logic                      dram_write_enable,
  output logic                      dram_wait,
  output logic [APP_ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [LINE_WIDTH-1:0]     app_wdf_data,
  output logic [LINE_WIDTH/8-1:0]   app_wdf_mask,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  input  logic                      app_wdf_rdy,
  input  logic [LINE_WIDTH-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid,
  input  logic                      init_calib_complete
);

  state_t           state_q, state_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             cmd_done_q, cmd_done_d;
  logic             data_done_q, data_done_d;

  logic [1:0]       word_sel;
  logic [TAG_W-1:0] req_tag;
  logic [127:0]     buf_line;
  logic [TAG_W-1:0] buf_tag;
  logic             buf_valid;
  logic             hit;
  logic [31:0]      buf_word;
  logic [31:0]      rsp_word;
  logic             fill_en;
  logic             word_we;
  logic             unused_addr_bits;

  assign word_sel = dram_addr[3:2];
  assign req_tag  = dram_addr[31:4];
  assign hit      = buf_valid && (buf_tag == req_tag);
  assign buf_word = buf_line[{word_sel, 5'b00000} +: 32];
  assign rsp_word = app_rd_data[{word_sel, 5'b00000} +: 32];

  assign unused_addr_bits = ^dram_addr[1:0];

  // Reset already clears the valid bit; no other event has to drop the line.
  line_buffer u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .invalidate (1'b0),
    .fill_en    (fill_en),
    .fill_data  (app_rd_data),
    .fill_tag   (req_tag),
    .word_we    (word_we),
    .word_sel   (word_sel),
    .word_data  (dram_write_data),
    .line_data  (buf_line),
    .tag        (buf_tag),
    .valid      (buf_valid)
  );

  assign app_addr     = {dram_addr[APP_ADDR_WIDTH-1:4], 4'b0000};
  assign app_wdf_data = {LINE_WORDS{dram_write_data}};
  assign app_wdf_mask = lane_mask(word_sel);
  assign app_wdf_end  = app_wdf_wren;

  always_comb begin
    state_d      = state_q;
    rd_data_d    = rd_data_q;
    cmd_done_d   = cmd_done_q;
    data_done_d  = data_done_q;
    dram_wait    = 1'b0;
    app_en       = 1'b0;
    app_cmd      = APP_CMD_READ;
    app_wdf_wren = 1'b0;
    fill_en      = 1'b0;
    word_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dram_read_enable || dram_write_enable) begin
          if (!init_calib_complete) begin
            dram_wait = 1'b1;
          end else if (dram_write_enable) begin
            // A write wins over a simultaneous read.
            dram_wait   = 1'b1;
            state_d     = ST_WR_XFER;
            cmd_done_d  = 1'b0;
            data_done_d = 1'b0;
            word_we     = hit;
          end else if (hit) begin
            rd_data_d = buf_word;
          end else begin
            dram_wait = 1'b1;
            state_d   = ST_RD_CMD;
          end
        end
      end

      ST_RD_CMD: begin
        dram_wait = 1'b1;
        app_en    = 1'b1;
        app_cmd   = APP_CMD_READ;
        if (app_rdy) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        dram_wait = 1'b1;
        if (app_rd_data_valid) begin
          fill_en   = 1'b1;
          rd_data_d = rsp_word;
          state_d   = ST_DONE;
        end
      end

      ST_WR_XFER: begin
        // Command and data channels handshake independently; leave once
        // both have been accepted, including in the same cycle.
        dram_wait    = 1'b1;
        app_cmd      = APP_CMD_WRITE;
        app_en       = !cmd_done_q;
        app_wdf_wren = !data_done_q;
        if (app_en && app_rdy) begin
          cmd_done_d = 1'b1;
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          data_done_d = 1'b1;
        end
        if (cmd_done_d && data_done_d) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_data_q   <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
    end
  end

  assign dram_read_data = rd_data_q;

endmodule
